// File: rtl/sobel_window_fetch_if.sv
// Handshake and data bundle for the Sobel window fetcher: the frame start
// request, the single-outstanding pixel memory read port and the tile
// output towards the gradient stage.
interface sobel_window_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [11:0][7:0]  data_buffer;
  logic              enable_calc;
  logic [7:0]        win_row;
  logic [7:0]        win_col;
  logic              busy;
  logic              done;

  // Fetcher side: issues reads, produces tiles.
  modport master (
    input  start, base_addr, rd_data, rd_valid,
    output rd_en, rd_addr, data_buffer, enable_calc, win_row, win_col, busy, done
  );

  // Environment side: memory responder and frame controller / tile consumer.
  modport slave (
    output start, base_addr, rd_data, rd_valid,
    input  rd_en, rd_addr, data_buffer, enable_calc, win_row, win_col, busy, done
  );
endinterface

// File: rtl/sobel_window_fetch.sv
// Sobel window fetcher: walks a byte-per-address grayscale image and builds
// 3-row x 4-column tiles. Column 0 of each image row gets a full 12-byte
// fetch; later tiles shift the two right columns left and fetch only the
// two new columns (6 bytes). One read outstanding at a time.
module sobel_window_fetch #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input logic                 clk,
  input logic                 n_rst,
  sobel_window_fetch_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CALC = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [7:0] LAST_COL = 8'(IMG_W - 4);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);

  logic [2:0]        state_r, state_nxt_s;
  logic [ADDR_W-1:0] base_r, base_nxt_s;
  logic [7:0]        row_r, row_nxt_s;
  logic [7:0]        col_r, col_nxt_s;
  logic [1:0]        k_r, k_nxt_s;
  logic [1:0]        j_r, j_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              shift_s;

  logic [11:0][7:0]  buf_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              enable_calc_r;
  logic              busy_r;
  logic              done_r;

  // Next-state and tile/byte position bookkeeping for the scan.
  always_comb begin
    state_nxt_s = state_r;
    base_nxt_s  = base_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    k_nxt_s     = k_r;
    j_nxt_s     = j_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          base_nxt_s  = bus.base_addr;
          row_nxt_s   = 8'd0;
          col_nxt_s   = 8'd0;
          k_nxt_s     = 2'd0;
          j_nxt_s     = 2'd0;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rd_valid) begin
          if (j_r == 2'd3) begin
            if (k_r == 2'd2) begin
              state_nxt_s = ST_CALC;
            end else begin
              // Next tile row: full fetch restarts at column 0, step fetch at 2.
              k_nxt_s     = k_r + 2'd1;
              j_nxt_s     = (col_r == 8'd0) ? 2'd0 : 2'd2;
              state_nxt_s = ST_REQ;
            end
          end else begin
            j_nxt_s     = j_r + 2'd1;
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_CALC: begin
        k_nxt_s = 2'd0;
        if (col_r == LAST_COL) begin
          if (row_r == LAST_ROW) begin
            state_nxt_s = ST_DONE;
          end else begin
            row_nxt_s   = row_r + 8'd1;
            col_nxt_s   = 8'd0;
            j_nxt_s     = 2'd0;
            state_nxt_s = ST_REQ;
          end
        end else begin
          col_nxt_s   = col_r + 8'd2;
          j_nxt_s     = 2'd2;
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Address of the byte about to be requested, wrapping modulo 2^ADDR_W.
  always_comb begin
    addr_nxt_s = base_nxt_s + ADDR_W'((32'(row_nxt_s) + 32'(k_nxt_s)) * 32'(IMG_W)
                                      + 32'(col_nxt_s) + 32'(j_nxt_s));
  end

  // Column reuse happens only when leaving CALC towards a step tile.
  always_comb begin
    shift_s = (state_r == ST_CALC) && (state_nxt_s == ST_REQ) && (col_nxt_s != 8'd0);
  end

  // Scan state and position registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      base_r  <= '0;
      row_r   <= 8'd0;
      col_r   <= 8'd0;
      k_r     <= 2'd0;
      j_r     <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      base_r  <= base_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      k_r     <= k_nxt_s;
      j_r     <= j_nxt_s;
    end
  end

  // Tile buffer: byte capture on read response, left shift on step.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_r <= '0;
    end else if ((state_r == ST_WAIT) && bus.rd_valid) begin
      buf_r[{k_r, j_r}] <= bus.rd_data;
    end else if (shift_s) begin
      buf_r[0] <= buf_r[2];
      buf_r[1] <= buf_r[3];
      buf_r[4] <= buf_r[6];
      buf_r[5] <= buf_r[7];
      buf_r[8] <= buf_r[10];
      buf_r[9] <= buf_r[11];
    end else begin
      buf_r <= buf_r;
    end
  end

  // Registered strobes and read address, decoded from the upcoming state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_en_r       <= 1'b0;
      rd_addr_r     <= '0;
      enable_calc_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      rd_en_r       <= (state_nxt_s == ST_REQ);
      enable_calc_r <= (state_nxt_s == ST_CALC);
      busy_r        <= (state_nxt_s != ST_IDLE);
      done_r        <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_REQ) begin
        rd_addr_r <= addr_nxt_s;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  assign bus.rd_en       = rd_en_r;
  assign bus.rd_addr     = rd_addr_r;
  assign bus.data_buffer = buf_r;
  assign bus.enable_calc = enable_calc_r;
  assign bus.win_row     = row_r;
  assign bus.win_col     = col_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Self-checking bench for sobel_window_fetch: memory responder with random
// latency, negedge monitor, and a reference model that derives every tile
// and read address straight from the image geometry.
module tb_sobel_window_fetch;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 16;
  localparam int NT     = (IMG_H - 2) * (IMG_W - 2) / 2;
  localparam int NF     = (IMG_H - 2) * (12 + ((IMG_W - 4) / 2) * 6);

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  sobel_window_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  sobel_window_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory and responder.
  logic [7:0]        mem [65536];
  int                lat_min = 1;
  int                lat_max = 1;
  int                next_lat = 1;
  logic              inject = 1'b0;
  logic [7:0]        inject_data = 8'h00;
  logic              resp_active = 1'b0;
  int                resp_cnt = 0;
  logic [ADDR_W-1:0] resp_addr = '0;
  int                overlap = 0;

  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      if (resp_active || (bus.rd_valid === 1'b1)) overlap <= overlap + 1;
      if (next_lat <= 1) begin
        bus.rd_valid <= 1'b1;
        bus.rd_data  <= mem[bus.rd_addr];
        resp_active  <= 1'b0;
      end else begin
        resp_active  <= 1'b1;
        resp_cnt     <= next_lat - 1;
        resp_addr    <= bus.rd_addr;
        bus.rd_valid <= 1'b0;
      end
    end else if (resp_active) begin
      if (resp_cnt == 1) begin
        bus.rd_valid <= 1'b1;
        bus.rd_data  <= mem[resp_addr];
        resp_active  <= 1'b0;
      end else begin
        resp_cnt     <= resp_cnt - 1;
        bus.rd_valid <= 1'b0;
      end
    end else if (inject) begin
      bus.rd_valid <= 1'b1;
      bus.rd_data  <= inject_data;
    end else begin
      bus.rd_valid <= 1'b0;
    end
    next_lat <= $urandom_range(lat_max, lat_min);
  end

  // Monitor: records read requests, tiles and done pulses.
  logic [ADDR_W-1:0] addr_q[$];
  int                addr_cyc_q[$];
  int                en_cyc_q[$];
  logic [11:0][7:0]  en_buf_q[$];
  logic [7:0]        en_row_q[$];
  logic [7:0]        en_col_q[$];
  int                done_cyc_q[$];
  bit                busy_hist [0:131071];

  always @(negedge clk) begin
    busy_hist[cyc[16:0]] <= bus.busy;
    if (n_rst) begin
      if (bus.rd_en) begin
        addr_q.push_back(bus.rd_addr);
        addr_cyc_q.push_back(cyc);
      end
      if (bus.enable_calc) begin
        en_cyc_q.push_back(cyc);
        en_buf_q.push_back(bus.data_buffer);
        en_row_q.push_back(bus.win_row);
        en_col_q.push_back(bus.win_col);
      end
      if (bus.done) done_cyc_q.push_back(cyc);
    end
  end

  // Reference model.
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [11:0][7:0]  exp_buf_q[$];
  int                exp_row_q[$];
  int                exp_col_q[$];
  logic [11:0][7:0]  ref_buf_q[$];

  function automatic logic [15:0] addr_of(input logic [15:0] base, input int y, input int x);
    return base + 16'(y * IMG_W + x);
  endfunction

  task automatic build_expected(input logic [15:0] base);
    exp_addr_q.delete(); exp_buf_q.delete(); exp_row_q.delete(); exp_col_q.delete();
    for (int r = 0; r <= IMG_H - 3; r++) begin
      for (int c = 0; c <= IMG_W - 4; c += 2) begin
        logic [11:0][7:0] t;
        for (int k = 0; k < 3; k++) begin
          for (int j = 0; j < 4; j++) begin
            t[4*k+j] = mem[addr_of(base, r + k, c + j)];
            if (c == 0 || j >= 2) exp_addr_q.push_back(addr_of(base, r + k, c + j));
          end
        end
        exp_buf_q.push_back(t);
        exp_row_q.push_back(r);
        exp_col_q.push_back(c);
      end
    end
  endtask

  task automatic fill_mem_linear();
    for (int a = 0; a < 65536; a++) mem[a] = a[7:0];
  endtask

  task automatic fill_mem_random();
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
  endtask

  function automatic int count_rd(input int lo, input int hi);
    int n = 0;
    foreach (addr_cyc_q[i]) if (addr_cyc_q[i] > lo && addr_cyc_q[i] < hi) n++;
    return n;
  endfunction

  task automatic clear_mon();
    addr_q.delete(); addr_cyc_q.delete(); en_cyc_q.delete(); en_buf_q.delete();
    en_row_q.delete(); en_col_q.delete(); done_cyc_q.delete();
  endtask

  // Pulse start, optionally pulse a second start mid-scan, wait for done.
  task automatic run_scan(input logic [15:0] base, input int restart_at, output int start_stamp);
    clear_mon();
    @(posedge clk); #1;
    bus.base_addr = base;
    bus.start = 1'b1;
    start_stamp = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base_addr = 16'h0000;
    for (int i = 1; i < 3000 && done_cyc_q.size() == 0; i++) begin
      if (i == restart_at) begin
        bus.start = 1'b1;
        bus.base_addr = 16'h0200;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL scan_timeout: got no done pulse, want one within 3000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rd_en, bus.enable_calc, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {bus.rd_en, bus.enable_calc, bus.busy, bus.done});
    end
    checks++;
    if (bus.data_buffer !== 96'h0 || bus.rd_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got buf %h addr %h want 0", bus.data_buffer, bus.rd_addr);
    end
    checks++;
    if (bus.win_row !== 8'h00 || bus.win_col !== 8'h00) begin
      errors++;
      $display("FAIL reset_pos: got row %h col %h want 0", bus.win_row, bus.win_col);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_basic_scan();
    int st;
    int dc;
    fill_mem_linear();
    lat_min = 1; lat_max = 1;
    run_scan(16'h0100, 0, st);
    build_expected(16'h0100);
    checks++;
    if (en_cyc_q.size() != NT) begin
      errors++; $display("FAIL basic_tiles: got %0d want %0d", en_cyc_q.size(), NT);
    end
    checks++;
    if (addr_q.size() != NF) begin
      errors++; $display("FAIL basic_fetches: got %0d want %0d", addr_q.size(), NF);
    end
    for (int i = 0; i < en_cyc_q.size() && i < NT; i++) begin
      int want_gap;
      want_gap = (i == 0) ? (en_cyc_q[0] - st + 0) : ((exp_col_q[i] == 0) ? 25 : 13);
      checks++;
      if (en_buf_q[i] !== exp_buf_q[i]) begin
        errors++; $display("FAIL basic_tile%0d_buf: got %h want %h", i, en_buf_q[i], exp_buf_q[i]);
      end
      checks++;
      if (en_row_q[i] !== 8'(exp_row_q[i]) || en_col_q[i] !== 8'(exp_col_q[i])) begin
        errors++; $display("FAIL basic_tile%0d_pos: got r%0d c%0d want r%0d c%0d",
                           i, en_row_q[i], en_col_q[i], exp_row_q[i], exp_col_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (en_cyc_q[i] - en_cyc_q[i-1] != want_gap) begin
          errors++; $display("FAIL basic_gap%0d: got %0d want %0d", i, en_cyc_q[i] - en_cyc_q[i-1], want_gap);
        end
      end
    end
    if (en_cyc_q.size() >= 4) begin
      checks++;
      if (en_cyc_q[0] - st != 25) begin
        errors++; $display("FAIL first_latency: got %0d want 25", en_cyc_q[0] - st);
      end
      checks++;
      if (en_buf_q[1][0] !== 8'h02 || en_buf_q[1][11] !== 8'h15 || en_buf_q[3][0] !== 8'h08 || en_buf_q[3][8] !== 8'h18) begin
        errors++; $display("FAIL spec_bytes: got %h %h %h %h want 02 15 08 18",
                           en_buf_q[1][0], en_buf_q[1][11], en_buf_q[3][0], en_buf_q[3][8]);
      end
      checks++;
      if (count_rd(en_cyc_q[0], en_cyc_q[1]) != 6 || count_rd(en_cyc_q[2], en_cyc_q[3]) != 12) begin
        errors++; $display("FAIL fetch_per_tile: got %0d and %0d want 6 and 12",
                           count_rd(en_cyc_q[0], en_cyc_q[1]), count_rd(en_cyc_q[2], en_cyc_q[3]));
      end
    end
    for (int i = 0; i < addr_q.size() && i < exp_addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== exp_addr_q[i]) begin
        errors++; $display("FAIL basic_addr%0d: got %h want %h", i, addr_q[i], exp_addr_q[i]);
      end
    end
    if (done_cyc_q.size() == 1 && en_cyc_q.size() > 0) begin
      dc = done_cyc_q[0];
      checks++;
      if (dc != en_cyc_q[en_cyc_q.size()-1] + 1) begin
        errors++; $display("FAIL done_timing: got %0d want %0d", dc, en_cyc_q[en_cyc_q.size()-1] + 1);
      end
      checks++;
      if (busy_hist[dc[16:0]] !== 1'b1 || busy_hist[17'(dc + 1)] !== 1'b0) begin
        errors++; $display("FAIL busy_fall: got %b%b want 10", busy_hist[dc[16:0]], busy_hist[17'(dc + 1)]);
      end
    end
    ref_buf_q = en_buf_q;
  endtask

  task automatic test_start_while_busy();
    int st;
    int bad = 0;
    fill_mem_linear();
    lat_min = 1; lat_max = 1;
    run_scan(16'h0100, 30, st);
    build_expected(16'h0100);
    foreach (addr_q[i]) if (addr_q[i][15:8] !== 8'h01 || addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (bad != 0 || addr_q.size() != NF) begin
      errors++; $display("FAIL busy_start_addrs: got %0d bad of %0d want 0 bad of %0d", bad, addr_q.size(), NF);
    end
    checks++;
    if (en_cyc_q.size() != NT || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL busy_start_tiles: got %0d tiles %0d done want %0d and 1", en_cyc_q.size(), done_cyc_q.size(), NT);
    end
  endtask

  task automatic test_variable_latency();
    int st;
    int ov0;
    fill_mem_linear();
    lat_min = 1; lat_max = 4;
    ov0 = overlap;
    run_scan(16'h0100, 0, st);
    build_expected(16'h0100);
    checks++;
    if (overlap != ov0) begin
      errors++; $display("FAIL var_outstanding: got %0d overlaps want 0", overlap - ov0);
    end
    checks++;
    if (en_cyc_q.size() != NT || addr_q.size() != NF) begin
      errors++; $display("FAIL var_counts: got %0d/%0d want %0d/%0d", en_cyc_q.size(), addr_q.size(), NT, NF);
    end
    for (int i = 0; i < en_buf_q.size() && i < ref_buf_q.size(); i++) begin
      checks++;
      if (en_buf_q[i] !== ref_buf_q[i] || en_buf_q[i] !== exp_buf_q[i]) begin
        errors++; $display("FAIL var_tile%0d: got %h want %h", i, en_buf_q[i], exp_buf_q[i]);
      end
    end
    // Spurious responses while idle must not disturb anything.
    inject_data = 8'hA5;
    inject = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.data_buffer !== exp_buf_q[NT-1] || bus.busy !== 1'b0 || addr_q.size() != NF) begin
      errors++; $display("FAIL idle_spurious: got buf %h busy %b reads %0d want %h 0 %0d",
                         bus.data_buffer, bus.busy, addr_q.size(), exp_buf_q[NT-1], NF);
    end
  endtask

  task automatic test_random_frames();
    logic [15:0] bases [3];
    int st;
    bases[0] = 16'hFFF5;
    bases[1] = 16'($urandom);
    bases[2] = 16'($urandom);
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 3; n++) begin
      int bad = 0;
      fill_mem_random();
      run_scan(bases[n], 0, st);
      build_expected(bases[n]);
      checks++;
      if (en_cyc_q.size() != NT || addr_q.size() != NF) begin
        errors++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", n, en_cyc_q.size(), addr_q.size(), NT, NF);
      end
      foreach (addr_q[i]) if (i < exp_addr_q.size() && addr_q[i] !== exp_addr_q[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand%0d_addrs: got %0d wrong addresses want 0 (base %h)", n, bad, bases[n]);
      end
      for (int i = 0; i < en_buf_q.size() && i < NT; i++) begin
        checks++;
        if (en_buf_q[i] !== exp_buf_q[i]) begin
          errors++; $display("FAIL rand%0d_tile%0d: got %h want %h", n, i, en_buf_q[i], exp_buf_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int st;
    fill_mem_linear();
    lat_min = 4; lat_max = 4;
    clear_mon();
    @(posedge clk); #1;
    bus.base_addr = 16'h0100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 500 && en_cyc_q.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20 && bus.rd_en !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.rd_en !== 1'b1 || en_cyc_q.size() != 1) begin
      errors++; $display("FAIL rst_setup: got rd_en %b tiles %0d want 1 and 1", bus.rd_en, en_cyc_q.size());
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.rd_en, bus.enable_calc, bus.busy, bus.done} !== 4'b0000 || bus.data_buffer !== 96'h0 ||
        bus.rd_addr !== 16'h0 || bus.win_row !== 8'h00 || bus.win_col !== 8'h00) begin
      errors++; $display("FAIL rst_outputs: got strobes %b buf %h addr %h row %h col %h want all 0",
                         {bus.rd_en, bus.enable_calc, bus.busy, bus.done}, bus.data_buffer, bus.rd_addr, bus.win_row, bus.win_col);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.data_buffer !== 96'h0 || bus.busy !== 1'b0 || en_cyc_q.size() != 1) begin
      errors++; $display("FAIL rst_late_valid: got buf %h busy %b tiles %0d want 0 0 1", bus.data_buffer, bus.busy, en_cyc_q.size());
    end
    lat_min = 1; lat_max = 1;
    run_scan(16'h0100, 0, st);
    build_expected(16'h0100);
    checks++;
    if (en_cyc_q.size() != NT || en_cyc_q[0] - st != 25 || en_row_q[0] !== 8'h00 || en_col_q[0] !== 8'h00) begin
      errors++; $display("FAIL rst_rescan: got %0d tiles latency %0d r%0d c%0d want %0d 25 r0 c0",
                         en_cyc_q.size(), en_cyc_q[0] - st, en_row_q[0], en_col_q[0], NT);
    end
    for (int i = 0; i < en_buf_q.size() && i < NT; i++) begin
      checks++;
      if (en_buf_q[i] !== exp_buf_q[i]) begin
        errors++; $display("FAIL rst_rescan_tile%0d: got %h want %h", i, en_buf_q[i], exp_buf_q[i]);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = 16'h0000;
    test_reset();
    test_basic_scan();
    test_start_while_busy();
    test_variable_latency();
    test_random_frames();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before 2000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
